mem_wb_ctrl: RTL and testbench
==============================

// Module: mem_wb_ctrl
// PURPOSE
// Memory/writeback stage controller for the pipelined RV32 core. Decodes the stage
// state code, drives PC redirect, register writeback and the data-memory port. Adds a
// parametrised store buffer that retires stores when memory is ready, load-after-store
// hazard handling, and a configurable-depth PC history for branch targets.
// PARAMETERS
// DATA_W    32  datapath width
// ADDR_W    32  address width
// SB_DEPTH  4   store-buffer entries; power of 2, >=2
// PC_LAG    2   cycles between fetch PC and this stage; branch base = PC delayed PC_LAG
// PORTS
// clk        in   1       clock, all state on rising edge
// reset      in   1       asynchronous reset, active-high
// state      in   4       stage state code (`IDLE,`RegWrite,`MemReadRegWrite,`MemWrite,
//                         `PCSelectWrite,`PCWrite,`LuiRegWrite from Defines.v)
// func3      in   3       access size/sign of current load/store
// pc         in   ADDR_W  current fetch PC
// imm        in   DATA_W  immediate
// rs2_data   in   DATA_W  store data
// alu_o      in   DATA_W  ALU result: address, branch condition or jump target
// fwd_b      in   2       bit0=1: load result taken from fwd_data
// mem_rdata  in   DATA_W  memory read data (combinational on mem_addr)
// mem_ready  in   1       memory accepts a write this cycle
// pc_we/pc_wdata    out 1/ADDR_W  PC redirect
// reg_we/reg_wdata  out 1/DATA_W  register writeback
// mem_we/mem_addr/mem_wdata/mem_func3  out 1/ADDR_W/DATA_W/3  memory port
// fwd_data   out  DATA_W  registered last writeback/store data
// stall_o    out  1       hold upstream pipeline this cycle
// BEHAVIOUR
// - Reset (async): buffer empty, pointers 0, fwd_data=0, PC history 0; while reset high
//   pc_we=1, pc_wdata=0, all other outputs 0.
// - PC history: PC_LAG-deep shift register of pc; hist_out = pc delayed PC_LAG cycles.
// - `IDLE: all enables 0. `RegWrite: reg_we=1, reg_wdata=alu_o. `LuiRegWrite: reg_wdata=imm.
// - `PCSelectWrite: alu_o!=0 -> pc_we=1, pc_wdata=hist_out+imm-4 (mod 2^ADDR_W); else pc_we=0.
// - `PCWrite: pc_we=1, pc_wdata=alu_o with bit0 cleared; reg_we=1, reg_wdata=hist_out.
// - `MemWrite: push {alu_o,rs2_data,func3} at tail. Full and no drain this cycle ->
//   stall_o=1, no push; full with drain same cycle -> push accepted, stall_o=0.
// - Drain: buffer non-empty, mem_ready=1, no load using port -> mem_we=1, head entry on
//   port, head advances. Combinational on mem_ready; zero added latency.
// - `MemReadRegWrite: load owns port (mem_addr=alu_o, mem_func3=func3), drain suppressed.
//   fwd_b[0]=1 -> reg_wdata=fwd_data. Else word-address match (alu_o[ADDR_W-1:2]) vs valid
//   entries: none -> reg_wdata=mem_rdata, reg_we=1; match -> see CONFIGURATION.
//   While stalled: reg_we=0; drain allowed (port released) so stall resolves.
// - fwd_data <= reg_wdata when reg_we&~stall_o, <= rs2_data on accepted push.
// - Pointers wrap mod SB_DEPTH; count SB_DEPTH = full, 0 = empty; push+pop same cycle
//   keeps count.
// CONFIGURATION
// MEM_WB_SB_FORWARD_EN defined: youngest matching entry with func3=3'b010 and func3 of
//   load=3'b010 forwards its data, reg_we=1, no stall; other matches stall until drained.
// Not defined: any match stalls until all matching entries drained; no forwarding path.
// TESTING
// reset high with state=`RegWrite -> pc_we=1, pc_wdata=0, reg_we=0; release -> reg_we=1.
// 5x `MemWrite, mem_ready=0, SB_DEPTH=4 -> 4 pushes, 5th stall_o=1; mem_ready=1 -> pushes.
// store 0xDEADBEEF @0x100 (buffered), load lw @0x100 -> with _EN reg_wdata=0xDEADBEEF no
//   stall; without _EN stall until drain, then reg_wdata=mem_rdata.
// PC_LAG=2, pc 0x10,0x14,0x18, `PCSelectWrite alu_o=1 imm=0x20 -> pc_wdata=0x2C.
// `PCWrite alu_o=0x203 -> pc_we=1, pc_wdata=0x202, reg_wdata=hist_out.
// reset asserted with 3 entries buffered -> empty next cycle, mem_we=0, nothing drained.

Source files
------------

// File: rtl/mem_wb_ctrl.sv
// Memory/writeback stage controller: store buffer, load-after-store hazard handling, PC history.
// Defining MEM_WB_SB_FORWARD_EN enables word store-to-load forwarding from the store buffer.
module mem_wb_ctrl #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int SB_DEPTH = 4,
    parameter int PC_LAG   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        state,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] pc,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic [DATA_W-1:0] alu_o,
    input  logic [1:0]        fwd_b,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              pc_we,
    output logic [ADDR_W-1:0] pc_wdata,
    output logic              reg_we,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        mem_func3,
    output logic [DATA_W-1:0] fwd_data,
    output logic              stall_o
);
    // State encodings as defined in Defines.v.
    localparam logic [3:0] IDLE            = 4'd0;
    localparam logic [3:0] RegWrite        = 4'd1;
    localparam logic [3:0] MemReadRegWrite = 4'd2;
    localparam logic [3:0] MemWrite        = 4'd3;
    localparam logic [3:0] PCSelectWrite   = 4'd4;
    localparam logic [3:0] PCWrite         = 4'd5;
    localparam logic [3:0] LuiRegWrite     = 4'd6;
    localparam int PTR_W = $clog2(SB_DEPTH);

    logic [ADDR_W-1:0] sbAddr  [SB_DEPTH];
    logic [DATA_W-1:0] sbData  [SB_DEPTH];
    logic [2:0]        sbFunc3 [SB_DEPTH];
    logic [PTR_W-1:0]  headPtr;
    logic [PTR_W-1:0]  tailPtr;
    logic [PTR_W-1:0]  scanIdx;
    logic [PTR_W:0]    sbCount;
    logic [ADDR_W-1:0] pcHist [PC_LAG];
    logic [ADDR_W-1:0] histOut;
    logic [ADDR_W-1:0] aluAddr;
    logic              sbEmpty, sbFull, isLoad, anyMatch, canForward;
    logic              loadStall, pushReq, pushOk, drainOk;
    logic [DATA_W-1:0] fwdEntryData;
    logic              unusedFwdB;

    assign aluAddr    = ADDR_W'(alu_o);
    assign histOut    = pcHist[PC_LAG-1];
    assign sbEmpty    = (sbCount == '0);
    assign sbFull     = (sbCount == (PTR_W+1)'(SB_DEPTH));
    assign unusedFwdB = fwd_b[1];

`ifdef MEM_WB_SB_FORWARD_EN
    logic [2:0]        youngF3;
    logic [DATA_W-1:0] youngData;
    assign canForward   = anyMatch && (youngF3 == 3'b010) && (func3 == 3'b010);
    assign fwdEntryData = youngData;
`else
    assign canForward   = 1'b0;
    assign fwdEntryData = '0;
`endif

    // Scan valid entries oldest to youngest so the last hit is the youngest match.
    always_comb begin
        anyMatch = 1'b0;
        scanIdx  = '0;
`ifdef MEM_WB_SB_FORWARD_EN
        youngF3   = 3'b000;
        youngData = '0;
`endif
        for (int k = 0; k < SB_DEPTH; k++) begin
            scanIdx = headPtr + PTR_W'(k);
            if (((PTR_W+1)'(k) < sbCount) &&
                (sbAddr[scanIdx][ADDR_W-1:2] == aluAddr[ADDR_W-1:2])) begin
                anyMatch = 1'b1;
`ifdef MEM_WB_SB_FORWARD_EN
                youngF3   = sbFunc3[scanIdx];
                youngData = sbData[scanIdx];
`endif
            end else begin
                anyMatch = anyMatch;
            end
        end
    end

    // Hazard, buffer handshake and output decode; reset forces the PC to zero.
    always_comb begin
        pc_we     = 1'b0;
        pc_wdata  = '0;
        reg_we    = 1'b0;
        reg_wdata = '0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_func3 = 3'b000;
        isLoad    = (state == MemReadRegWrite);
        loadStall = isLoad && !fwd_b[0] && anyMatch && !canForward;
        // A stalled load releases the port so the conflicting store can drain.
        drainOk   = !sbEmpty && mem_ready && (!isLoad || loadStall) && !reset;
        pushReq   = (state == MemWrite);
        pushOk    = pushReq && (!sbFull || drainOk) && !reset;
        stall_o   = (pushReq && !pushOk) || loadStall;

        if (drainOk) begin
            mem_we    = 1'b1;
            mem_addr  = sbAddr[headPtr];
            mem_wdata = sbData[headPtr];
            mem_func3 = sbFunc3[headPtr];
        end else if (isLoad) begin
            mem_addr  = aluAddr;
            mem_func3 = func3;
        end else begin
            mem_we = 1'b0;
        end

        case (state)
            RegWrite: begin
                reg_we    = 1'b1;
                reg_wdata = alu_o;
            end
            LuiRegWrite: begin
                reg_we    = 1'b1;
                reg_wdata = imm;
            end
            PCSelectWrite: begin
                if (alu_o != '0) begin
                    pc_we    = 1'b1;
                    pc_wdata = histOut + ADDR_W'(imm) - ADDR_W'(32'd4);
                end else begin
                    pc_we = 1'b0;
                end
            end
            PCWrite: begin
                pc_we     = 1'b1;
                pc_wdata  = {aluAddr[ADDR_W-1:1], 1'b0};
                reg_we    = 1'b1;
                reg_wdata = DATA_W'(histOut);
            end
            MemReadRegWrite: begin
                if (fwd_b[0]) begin
                    reg_we    = 1'b1;
                    reg_wdata = fwd_data;
                end else if (!anyMatch) begin
                    reg_we    = 1'b1;
                    reg_wdata = mem_rdata;
                end else if (canForward) begin
                    reg_we    = 1'b1;
                    reg_wdata = fwdEntryData;
                end else begin
                    reg_we = 1'b0;
                end
            end
            IDLE, MemWrite: begin
                reg_we = 1'b0;
            end
            default: begin
                reg_we = 1'b0;
            end
        endcase

        if (reset) begin
            pc_we     = 1'b1;
            pc_wdata  = '0;
            reg_we    = 1'b0;
            reg_wdata = '0;
            mem_we    = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
            mem_func3 = 3'b000;
            stall_o   = 1'b0;
        end else begin
            pc_we = pc_we;
        end
    end

    // Store buffer payload; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            sbAddr[tailPtr]  <= aluAddr;
            sbData[tailPtr]  <= rs2_data;
            sbFunc3[tailPtr] <= func3;
        end
    end

    // Buffer pointers, occupancy and the forwarding register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            headPtr  <= '0;
            tailPtr  <= '0;
            sbCount  <= '0;
            fwd_data <= '0;
        end else begin
            if (pushOk)  tailPtr <= tailPtr + PTR_W'(1);
            if (drainOk) headPtr <= headPtr + PTR_W'(1);
            case ({pushOk, drainOk})
                2'b10:   sbCount <= sbCount + (PTR_W+1)'(1);
                2'b01:   sbCount <= sbCount - (PTR_W+1)'(1);
                default: sbCount <= sbCount;
            endcase
            if (pushOk)                  fwd_data <= rs2_data;
            else if (reg_we && !stall_o) fwd_data <= reg_wdata;
        end
    end

    // Fetch-PC delay line supplying the branch base of this instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PC_LAG; i++) pcHist[i] <= '0;
        end else begin
            pcHist[0] <= pc;
            for (int i = 1; i < PC_LAG; i++) pcHist[i] <= pcHist[i-1];
        end
    end
endmodule

// File: tb/tb_mem_wb_ctrl.sv
// Directed self-checking bench for mem_wb_ctrl (default parameters, small memory model).
module tb_mem_wb_ctrl;
    localparam logic [3:0] IDLE = 4'd0, RW = 4'd1, MR = 4'd2, MW = 4'd3,
                           PCS = 4'd4, PCW = 4'd5, LUI = 4'd6;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  state;
    logic [2:0]  func3;
    logic [31:0] pc, imm, rs2_data, alu_o, mem_rdata;
    logic [1:0]  fwd_b;
    logic        mem_ready;
    logic        pc_we, reg_we, mem_we, stall_o;
    logic [31:0] pc_wdata, reg_wdata, mem_addr, mem_wdata, fwd_data;
    logic [2:0]  mem_func3;
    logic [31:0] memArr [256];
    int nChecks = 0, nPass = 0, nFail = 0;

    mem_wb_ctrl #(.DATA_W(32), .ADDR_W(32), .SB_DEPTH(4), .PC_LAG(2)) dut (
        .clk(clk), .reset(reset), .state(state), .func3(func3), .pc(pc), .imm(imm),
        .rs2_data(rs2_data), .alu_o(alu_o), .fwd_b(fwd_b), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .pc_we(pc_we), .pc_wdata(pc_wdata), .reg_we(reg_we),
        .reg_wdata(reg_wdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_func3(mem_func3), .fwd_data(fwd_data), .stall_o(stall_o));

    always #5 clk = ~clk;

    assign mem_rdata = memArr[mem_addr[9:2]];
    always @(posedge clk) if (mem_we) memArr[mem_addr[9:2]] <= mem_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) nPass++;
        else begin
            nFail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; state = RW; func3 = 3'b010; pc = 32'h0; imm = 32'h0;
        rs2_data = 32'h0; alu_o = 32'h55; fwd_b = 2'b00; mem_ready = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_pc_we", {31'd0, pc_we}, 32'd1);
        chk("rst_pc_wdata", pc_wdata, 32'h0);
        chk("rst_reg_we", {31'd0, reg_we}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_fwd_data", fwd_data, 32'h0);
        adv(); reset = 1'b0;
        @(negedge clk);
        chk("rw_reg_we", {31'd0, reg_we}, 32'd1);
        chk("rw_reg_wdata", reg_wdata, 32'h55);
        chk("rw_pc_we", {31'd0, pc_we}, 32'd0);
        adv(); state = LUI; imm = 32'h12345000;
        @(negedge clk);
        chk("fwd_after_rw", fwd_data, 32'h55);
        chk("lui_reg_wdata", reg_wdata, 32'h12345000);

        // PC history and branches
        adv(); state = IDLE; pc = 32'h10;
        @(negedge clk);
        chk("idle_reg_we", {31'd0, reg_we}, 32'd0);
        adv(); pc = 32'h14;
        adv(); pc = 32'h18; state = PCS; alu_o = 32'h1; imm = 32'h20;
        @(negedge clk);
        chk("pcs_pc_we", {31'd0, pc_we}, 32'd1);
        chk("pcs_pc_wdata", pc_wdata, 32'h2C);
        adv(); pc = 32'h1C; state = PCW; alu_o = 32'h203;
        @(negedge clk);
        chk("pcw_pc_we", {31'd0, pc_we}, 32'd1);
        chk("pcw_pc_wdata", pc_wdata, 32'h202);
        chk("pcw_reg_wdata", reg_wdata, 32'h14);
        adv(); state = PCS; alu_o = 32'h0;
        @(negedge clk);
        chk("pcs_not_taken", {31'd0, pc_we}, 32'd0);

        // Fill store buffer with memory not ready; fifth store stalls
        for (int k = 0; k < 5; k++) begin
            adv(); state = MW; alu_o = 32'h100 + 32'(4 * k); rs2_data = 32'hA0 + 32'(k);
            @(negedge clk);
            chk("fill_stall", {31'd0, stall_o}, (k == 4) ? 32'd1 : 32'd0);
            chk("fill_mem_we", {31'd0, mem_we}, 32'd0);
        end
        adv(); mem_ready = 1'b1;
        @(negedge clk);
        chk("full_drain_stall", {31'd0, stall_o}, 32'd0);
        chk("full_drain_addr", mem_addr, 32'h100);
        chk("full_drain_data", mem_wdata, 32'hA0);
        for (int k = 1; k < 5; k++) begin
            adv(); state = IDLE;
            @(negedge clk);
            chk("drain_we", {31'd0, mem_we}, 32'd1);
            chk("drain_addr", mem_addr, 32'h100 + 32'(4 * k));
            chk("drain_data", mem_wdata, 32'hA0 + 32'(k));
        end
        adv();
        @(negedge clk);
        chk("drained_empty", {31'd0, mem_we}, 32'd0);
        chk("fwd_after_push", fwd_data, 32'hA4);

        // Load after buffered store to the same word
        adv(); mem_ready = 1'b0; state = MW; alu_o = 32'h100; rs2_data = 32'hDEADBEEF;
        @(negedge clk);
        chk("las_push_stall", {31'd0, stall_o}, 32'd0);
        adv(); state = MR; alu_o = 32'h100; func3 = 3'b010;
        @(negedge clk);
`ifdef MEM_WB_SB_FORWARD_EN
        chk("las_fwd_stall", {31'd0, stall_o}, 32'd0);
        chk("las_fwd_reg_we", {31'd0, reg_we}, 32'd1);
        chk("las_fwd_data", reg_wdata, 32'hDEADBEEF);
        chk("las_fwd_no_drain", {31'd0, mem_we}, 32'd0);
        adv(); state = IDLE; mem_ready = 1'b1;
        @(negedge clk);
        chk("las_drain_addr", mem_addr, 32'h100);
`else
        chk("las_stall", {31'd0, stall_o}, 32'd1);
        chk("las_stall_reg_we", {31'd0, reg_we}, 32'd0);
        chk("las_stall_mem_we", {31'd0, mem_we}, 32'd0);
        adv(); mem_ready = 1'b1;
        @(negedge clk);
        chk("las_drain_stall", {31'd0, stall_o}, 32'd1);
        chk("las_drain_we", {31'd0, mem_we}, 32'd1);
        chk("las_drain_addr", mem_addr, 32'h100);
        chk("las_drain_data", mem_wdata, 32'hDEADBEEF);
`endif
        chk("las_drain_we2", {31'd0, mem_we}, 32'd1);
        adv(); state = MR; alu_o = 32'h100;
        @(negedge clk);
        chk("las_load_stall", {31'd0, stall_o}, 32'd0);
        chk("las_load_reg_we", {31'd0, reg_we}, 32'd1);
        chk("las_load_data", reg_wdata, 32'hDEADBEEF);
        chk("las_load_addr", mem_addr, 32'h100);
        chk("las_load_f3", {29'd0, mem_func3}, 32'd2);

        // Non-matching load, then fwd_b bypass
        adv(); alu_o = 32'h104;
        @(negedge clk);
        chk("ld_mem_data", reg_wdata, 32'hA1);
        adv(); state = RW; alu_o = 32'h77;
        adv(); state = MR; alu_o = 32'h108; fwd_b = 2'b01;
        @(negedge clk);
        chk("ld_fwdb_we", {31'd0, reg_we}, 32'd1);
        chk("ld_fwdb_data", reg_wdata, 32'h77);

        // Reset discards buffered stores
        fwd_b = 2'b00; mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            adv(); state = MW; alu_o = 32'h200 + 32'(4 * k); rs2_data = 32'hB0 + 32'(k);
        end
        adv(); reset = 1'b1; state = IDLE; mem_ready = 1'b1;
        @(negedge clk);
        chk("rst2_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst2_pc_we", {31'd0, pc_we}, 32'd1);
        adv(); reset = 1'b0;
        @(negedge clk);
        chk("rst2_empty_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst2_fwd_data", fwd_data, 32'h0);
        adv(); state = MR; alu_o = 32'h200; func3 = 3'b010;
        @(negedge clk);
        chk("rst2_no_match_stall", {31'd0, stall_o}, 32'd0);
        chk("rst2_no_match_we", {31'd0, reg_we}, 32'd1);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule
